alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Instruction-level controller for the 8-bit combinational `alu`. It owns a small register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads the operands, drives the ALU ports, captures `o_main`/`carry_out`, writes the result back to the register file, and presents the result downstream. It sits between an instruction source (test sequencer or future decoder) and one `alu` instance.

Parameters:
- DATA_W, 8, ALU operand/result width.
- NREGS, 4, register-file depth.
- RA_W, 2, register address width (log2 NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  block can accept an instruction.
- instr  input  16  instruction word:
  - [15:13] op
  - [12:11] rd
  - [10:9] rs1
  - [8:7] rs2
  - [7:0] imm (op 110 only; overlaps rs2)
- alu_i_1  output  DATA_W  to alu i_1.
- alu_i_2  output  DATA_W  to alu i_2.
- alu_op_code  output  3  to alu op_code.
- alu_o_main  input  DATA_W  from alu o_main.
- alu_carry_out  input  2  from alu carry_out.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res_data  output  DATA_W  result value.
- res_rd  output  RA_W  destination register of result.
- res_flags  output  2  captured carry_out.
- err  output  1  one-cycle pulse on illegal opcode.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: instr_ready=1, res_valid=0, err=0, busy=0. All other outputs reset to 0: res_data, res_rd, res_flags, alu_i_1, alu_i_2, alu_op_code. Register file reset to all zeros. Reset asserted in any state aborts the operation, drops any pending result with no write-back, and returns to IDLE.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT are ALU ops.
  - 110 REG_WRITE: rd <= imm; the ALU is not used.
  - 111 is illegal.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr, then:
    - op 111: stay IDLE, pulse err for exactly 1 cycle, no write, no result.
    - op 110: go to WB; load res_data=imm, res_flags=0, res_rd=rd; write regfile[rd] on the same edge.
    - otherwise: go to READ.
- READ: register alu_i_1=regfile[rs1], alu_i_2=regfile[rs2], alu_op_code=op, then go to EXEC. For op 101, alu_i_2 is still driven from rs2; the ALU ignores it.
- EXEC:
  - ALU outputs settle combinationally this cycle.
  - On the edge: res_data<=alu_o_main, res_flags<=alu_carry_out, res_rd<=rd, regfile[rd]<=alu_o_main; go to WB.
- WB:
  - res_valid=1. res_data, res_rd and res_flags are held stable until res_valid&&res_ready.
  - On the handshake, go to IDLE; res_valid drops on the next cycle.
- Latency, counted from the accepting edge:
  - ALU op: res_valid first high 3 cycles later (READ, EXEC, WB).
  - REG_WRITE: res_valid first high 1 cycle later.
- Throughput: one instruction in flight. instr_ready=0 in READ/EXEC/WB, so there is no overlap. An ALU instruction accepted back-to-back after a WB handshake uses its max rate of 1 instr per 4 cycles.
- Hazards: none. The write-back completes before the next acceptance, so a following read of rd sees the new value.
- Same register for all operands: rd==rs1==rs2 is legal. Operands use the pre-write value; rd is overwritten in EXEC.
- ALU output hold: alu_* outputs hold their last driven values outside READ/EXEC.
- Arithmetic: the block performs no arithmetic. Width and overflow behaviour is entirely the ALU's. The result is truncated to DATA_W by construction.

Test Plan:
- Reset: assert rst 2 cycles -> instr_ready=1, res_valid=0, busy=0, err=0; all regs read back 0 via ADD r0=r0+r1 -> res_data=0.
- REG_WRITE r0=2, r1=3, then ADD rd=2,rs1=0,rs2=1:
  - ADD gives res_valid exactly 3 cycles after acceptance, res_data=5, res_rd=2.
  - Each REG_WRITE gives res_valid 1 cycle after acceptance.
- Load r1=3; SUB r3=r1-r1 -> res_data=0. Load r0=8'hFF, r1=8'h01; ADD -> res_data=0, res_flags equal to alu_carry_out as sampled in EXEC.
- Backpressure: hold res_ready=0 for 5 cycles in WB -> res_valid, res_data, res_flags stable; instr_ready=0 and instr_valid ignored throughout; release -> IDLE next cycle.
- Illegal op 111 -> err high exactly 1 cycle, no res_valid, register file unchanged (verified by a subsequent OR readback).
- Assert rst during EXEC of AND -> next cycle IDLE, res_valid=0, destination register still holds its reset value 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction-level controller wrapped around one combinational alu.
// It accepts one instruction at a time, reads operands from a small register file,
// drives the alu, writes the result back and presents it downstream.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for an instruction; illegal opcodes pulse err here
// READ  | register file operands and opcode are loaded onto the alu ports
// EXEC  | alu settles; result, flags and write-back are captured on the edge
// WB    | result is presented and held until res_ready
module alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_i_1,
    output logic [DATA_W-1:0] alu_i_2,
    output logic [2:0]        alu_op_code,
    input  logic [DATA_W-1:0] alu_o_main,
    input  logic [1:0]        alu_carry_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [RA_W-1:0]   res_rd,
    output logic [1:0]        res_flags,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_WR  = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    state_t            state;

    logic [2:0]        op_q;
    logic [RA_W-1:0]   rd_q;
    logic [RA_W-1:0]   rs1_q;
    logic [RA_W-1:0]   rs2_q;

    logic [DATA_W-1:0] regs [NREGS];

    logic [2:0]        in_op;
    logic [RA_W-1:0]   in_rd;
    logic [RA_W-1:0]   in_rs1;
    logic [RA_W-1:0]   in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic              accept;

    logic              wr_en;
    logic [RA_W-1:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREGS-1:0]  wr_sel;

    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;

    // Instruction field extraction; imm overlaps the rs2 field on purpose.
    assign in_op  = instr[15:13];
    assign in_rd  = instr[12:11];
    assign in_rs1 = instr[10:9];
    assign in_rs2 = instr[8:7];
    assign in_imm = instr[7:0];
    assign accept = instr_valid && instr_ready;

    assign rd_data_1 = regs[rs1_q];
    assign rd_data_2 = regs[rs2_q];

    // Write-port select: REG_WRITE writes on its accepting edge, ALU ops on the EXEC edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = in_rd;
        wr_data = in_imm;
        if ((state == IDLE) && accept && (in_op == OP_WR)) begin
            wr_en = 1'b1;
        end else if (state == EXEC) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = alu_o_main;
        end
        for (int i = 0; i < NREGS; i++) begin
            wr_sel[i] = wr_en && (wr_addr == RA_W'(i));
        end
    end

    // Register file storage with one decoded write port; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Sequencing FSM; every output is a register so downstream sees glitch-free values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            err         <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_rd      <= '0;
            res_flags   <= '0;
            alu_i_1     <= '0;
            alu_i_2     <= '0;
            alu_op_code <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        rs1_q <= in_rs1;
                        rs2_q <= in_rs2;
                        if (in_op == OP_ILL) begin
                            // Illegal opcode is rejected without leaving IDLE.
                            err <= 1'b1;
                        end else if (in_op == OP_WR) begin
                            res_data    <= in_imm;
                            res_flags   <= 2'b00;
                            res_rd      <= in_rd;
                            res_valid   <= 1'b1;
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                            state       <= WB;
                        end else begin
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                            state       <= READ;
                        end
                    end
                end
                READ: begin
                    // NOT still gets rs2 on i_2; the alu simply ignores it.
                    alu_i_1     <= rd_data_1;
                    alu_i_2     <= rd_data_2;
                    alu_op_code <= op_q;
                    state       <= EXEC;
                end
                EXEC: begin
                    res_data  <= alu_o_main;
                    res_flags <= alu_carry_out;
                    res_rd    <= rd_q;
                    res_valid <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    res_valid   <= 1'b0;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
